// File: rtl/aes_subbytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine: one 128-bit state in, LANES S-box
// lookups per cycle, substituted state out over a valid/ready handshake.
module aes_subbytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NBEATS = 16 / LANES;
    localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    // Byte x of each table lives at [2047-8x -: 8]; rows are 16 entries.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t          state, state_nxt;
    logic [127:0]    work;
    logic            mode;
    logic [CW-1:0]   beat;

    function automatic logic [7:0] sub_byte(input logic inv, input logic [7:0] x);
        return inv ? INV_SBOX[2047 - 8 * int'(x) -: 8] : SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SUB;
            SUB:     if (beat == LAST_BEAT) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            mode  <= 1'b0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        mode <= in_inv;
                        beat <= '0;
                    end
                end
                SUB: begin
                    for (int l = 0; l < LANES; l++) begin
                        work[127 - 8 * (int'(beat) * LANES + l) -: 8]
                            <= sub_byte(mode, work[127 - 8 * (int'(beat) * LANES + l) -: 8]);
                    end
                    // With a single beat the counter stays pinned at zero.
                    if (NBEATS > 1) beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset gating keeps in_ready low through the reset cycle itself.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Scoreboard bench for aes_subbytes_engine: one instance per legal LANES value, with
// the full directed sequence on LANES=4 and FIPS-197 vectors on the others.
module tb_aes_subbytes_engine;
    localparam int NI = 5;
    localparam int LANE_TAB [NI] = '{1, 2, 4, 8, 16};
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] sbox_m [256];
    logic [7:0] inv_m [256];
    logic model_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127 - 8 * i -: 8] = inv ? inv_m[d[127 - 8 * i -: 8]] : sbox_m[d[127 - 8 * i -: 8]];
        return r;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    initial begin
        logic [7:0] iv, b;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            b = iv;
            sbox_m[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            inv_m[sbox_m[x]] = 8'(x);
        end
        model_ready = 1'b1;
    end

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int L  = LANE_TAB[g];
        localparam int NB = 16 / L;

        logic rst = 1'b1, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
        logic in_ready, out_valid, busy;
        logic [127:0] in_data = '0, out_data;
        logic prev_valid = 1'b0;
        logic fin = 1'b0;
        exp_t q [$];

        aes_subbytes_engine #(.LANES(L)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
            .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
            .out_data(out_data), .busy(busy)
        );

        always @(negedge clk) begin
            exp_t e;
            if (rst === 1'b1) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid === 1'b1 && !prev_valid) begin
                    check($sformatf("out_expected_l%0d", L), 128'(q.size() != 0), 128'd1);
                    if (q.size() != 0)
                        check($sformatf("latency_l%0d", L), 128'(cyc - q[0].acc), 128'(NB));
                end
                if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    check($sformatf("data_l%0d", L), out_data, e.data);
                end
                prev_valid = (out_valid === 1'b1);
            end
        end

        task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                            output int acc);
            exp_t e;
            int n;
            n = 0;
            @(negedge clk);
            in_valid = 1'b1; in_data = d; in_inv = inv;
            while (in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("accept_l%0d", L), 128'(in_ready), 128'd1);
            e.data = exp;
            e.acc  = cyc + 1;
            acc    = e.acc;
            q.push_back(e);
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((q.size() != 0 || busy) && n < 300) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("drain_l%0d", L), 128'(q.size()), 128'd0);
        endtask

        task automatic do_reset();
            rst = 1'b1; in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("ready_in_rst_l%0d", L), 128'(in_ready), 128'd0);
            rst = 1'b0;
            @(negedge clk);
            check("rst_out_valid", 128'(out_valid), 128'd0);
            check("rst_out_data", out_data, 128'd0);
            check("rst_in_ready", 128'(in_ready), 128'd1);
            check("rst_busy", 128'(busy), 128'd0);
        endtask

        if (L == 4) begin : g_main
            initial begin
                logic [127:0] blk, fw, d;
                logic inv;
                int acc, last;
                wait (model_ready);
                do_reset();

                send(FIPS_IN, 1'b0, FIPS_OUT, acc);
                send(FIPS_OUT, 1'b1, FIPS_IN, acc);
                send({16{8'h63}}, 1'b1, 128'd0, acc);
                in_valid = 1'b0;
                drain();

                for (int b = 0; b < 16; b++) begin
                    for (int j = 0; j < 16; j++) blk[127 - 8 * j -: 8] = 8'(b * 16 + j);
                    fw = sub_model(blk, 1'b0);
                    send(blk, 1'b0, fw, acc);
                    send(fw, 1'b1, blk, acc);
                end
                in_valid = 1'b0;
                drain();

                // Abort a block mid-substitution; the monitor flags any stray output.
                send(FIPS_IN, 1'b0, FIPS_OUT, acc);
                in_valid = 1'b0;
                @(negedge clk);
                q.delete();
                do_reset();
                repeat (NB + 6) @(negedge clk);

                out_ready = 1'b0;
                send(FIPS_IN, 1'b0, FIPS_OUT, acc);
                in_valid = 1'b0;
                for (int n = 0; n < 50 && out_valid !== 1'b1; n++) @(negedge clk);
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    in_valid = 1'($urandom); in_inv = 1'($urandom);
                    in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    check("bp_in_ready", 128'(in_ready), 128'd0);
                    check("bp_out_valid", 128'(out_valid), 128'd1);
                    check("bp_out_data", out_data, FIPS_OUT);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("post_hs_in_ready", 128'(in_ready), 128'd1);
                check("post_hs_busy", 128'(busy), 128'd0);
                check("post_hs_hold", out_data, FIPS_OUT);
                repeat (NB + 4) @(negedge clk);
                check("no_second_block", 128'(busy), 128'd0);

                last = 0;
                for (int k = 0; k < 10; k++) begin
                    d = {$urandom(), $urandom(), $urandom(), $urandom()};
                    inv = 1'($urandom);
                    send(d, inv, sub_model(d, inv), acc);
                    if (k > 0) check("stream_period", 128'(acc - last), 128'(NB + 2));
                    last = acc;
                end
                in_valid = 1'b0;
                drain();
                fin = 1'b1;
            end
        end else begin : g_lanes
            initial begin
                int acc;
                wait (model_ready);
                do_reset();
                send(FIPS_IN, 1'b0, FIPS_OUT, acc);
                send(FIPS_OUT, 1'b1, FIPS_IN, acc);
                send({16{8'h63}}, 1'b1, 128'd0, acc);
                in_valid = 1'b0;
                drain();
                fin = 1'b1;
            end
        end
    end

    initial begin
        logic all_fin;
        all_fin = 1'b0;
        for (int n = 0; n < 20000 && !all_fin; n++) begin
            @(posedge clk);
            all_fin = inst[0].fin & inst[1].fin & inst[2].fin & inst[3].fin & inst[4].fin;
        end
        check("completion", 128'(all_fin), 128'd1);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_subbytes_engine.md
# aes_subbytes_engine

Iterative, parametrised AES SubBytes / InvSubBytes engine. It accepts one 128-bit AES state over a valid/ready handshake and substitutes LANES bytes per cycle through the shared forward or inverse S-box tables from the AES package. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round datapath; LANES trades area (S-box instances) against cycles per block.

## Interface
- LANES, default 4: S-box lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration-time error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input state present.
- in_ready  out  1  engine can accept a state.
- in_inv  in  1  0 = forward SBOX, 1 = INV_SBOX; sampled only at input handshake.
- in_data  in  128  input state; byte i (i = 0..15) is in_data[127-8i -: 8] (FIPS-197 order).
- out_valid  out  1  substituted state available.
- out_ready  in  1  downstream accepts the state.
- out_data  out  128  substituted state, same byte ordering.
- busy  out  1  high in SUB or DONE.

## Operation
- NBEATS = 16/LANES. Internal state: 2-bit FSM, 128-bit work register, mode bit, beat counter of width max(1, clog2(NBEATS)).
- IDLE: in_ready = 1. On in_valid & in_ready, load work register with in_data, latch in_inv, clear beat counter, go to SUB.
- SUB: on each beat k (0..NBEATS-1), replace bytes k·LANES .. k·LANES+LANES-1 of the work register with the table lookup selected by the latched mode. Other bytes are untouched. Increment k. On the beat with k = NBEATS-1, go to DONE.
- DONE: out_valid = 1, out_data = work register. On out_valid & out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid in any other state is ignored, and in_data/in_inv are not sampled.
- Changes to in_inv or in_data after the accepting edge have no effect on the block in flight.
- out_data is driven from the work register only. It holds its value in every state other than SUB, so the last result remains visible after its handshake. Consumers must still qualify it with out_valid.
- LANES = 16: SUB lasts exactly one cycle; the counter is unused and constant 0.
- Forward and inverse tables are byte-exact copies of the package SBOX / INV_SBOX. INV_SBOX[SBOX[x]] = x for all 256 x.

## Timing
- Reset values: in_ready = 0 during the reset cycle and 1 on the first cycle after; out_valid = 0; out_data = 128'h0; busy = 0; FSM = IDLE; counter = 0; mode = 0.
- Reset taken in any state aborts the block in flight with no output. The next state is IDLE regardless of in_valid/out_ready in the reset cycle.
- Latency: if the input handshake occurs at edge t, out_valid rises after edge t+NBEATS. This is 4 cycles for LANES = 4 and 1 cycle for LANES = 16.
- out_valid stays high and out_data stays stable until the out_ready handshake. Unbounded backpressure is legal.
- After an output handshake at edge u, in_ready is high in the cycle following u. Minimum block period is NBEATS+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. All outputs are registered or decoded from the FSM.

## Test plan
- Reset/idle: assert rst for 2 cycles mid-SUB with LANES = 4 -> out_valid = 0, out_data = 0, in_ready = 1 next cycle, busy = 0, no output ever emitted for the aborted block.
- FIPS-197 forward: in_data = 193de3bea0f4e22b9ac68d2ae9f84808, in_inv = 0 -> out_data = d42711aee0bf98f1b8b45de51e415230, out_valid exactly NBEATS cycles after accept. Run for each LANES in {1, 2, 4, 8, 16}.
- Inverse: in_data = d42711aee0bf98f1b8b45de51e415230, in_inv = 1 -> out_data = 193de3bea0f4e22b9ac68d2ae9f84808. Also check that in_data = all 63 with in_inv = 1 gives all 00.
- Exhaustive table: 16 blocks covering bytes 00..ff in order, forward then inverse of each result -> forward bytes match SBOX (e.g. 00->63, 53->ed, ff->16) and the round trip returns the original bytes.
- Backpressure and mode stability: hold out_ready low for 20 cycles while toggling in_valid, in_inv and in_data -> out_data unchanged, in_ready = 0 throughout, no second block accepted. Release out_ready -> single output handshake, then in_ready = 1 next cycle.
- Back-to-back stream: in_valid and out_ready held high for 10 random blocks with random modes -> each output matches the software model in order, with a period of NBEATS+2 cycles per block.
